// File: rtl/ser_cmp_pkg.sv
// Shared types and defaults for the serial pair serializer and its MSB-first comparator.
// Word width default and the two-state serializer FSM encoding.
package ser_cmp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_W_DEFAULT = 8;

endpackage

// File: rtl/msb_first_shift_reg.sv
// W-bit left shift register with parallel load and zero fill; msb_out is the bit on the wire.
// Load has priority over shift so a back-to-back reload on the last bit takes effect.
module msb_first_shift_reg
    import ser_cmp_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb_out
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= din;
        end else if (shift) begin
            sh_q <= {sh_q[W-2:0], 1'b0};
        end
    end

    assign msb_out = sh_q[W-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes an accepted A/B word pair MSB first (MSB at T+1, LSB at T+W) with first/last marks and a cmp_clear pulse.
// Option SER_PAIR_BACK_TO_BACK_EN: also ready on the LSB cycle, giving gapless W-cycle words; otherwise ready only in IDLE.
module serial_pair_serializer_msb_first
    import ser_cmp_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_valid,
    output logic         ser_first,
    output logic         ser_last,
    output logic         cmp_clear
);

    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    ser_state_t    state_q;
    ser_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic          in_shift;
    logic          cnt_zero;
    logic          ready_raw;
    logic          accept;
    logic          msb_a;
    logic          msb_b;

    assign in_shift = (state_q == SHIFT);
    assign cnt_zero = (cnt_q == '0);

`ifdef SER_PAIR_BACK_TO_BACK_EN
    assign ready_raw = !in_shift || cnt_zero;
`else
    assign ready_raw = !in_shift;
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: if (cnt_zero && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter parks at zero once the LSB has gone out; it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_MAX;
        end else if (in_shift && !cnt_zero) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    msb_first_shift_reg #(.W(W)) u_sh_a (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (in_shift),
        .din     (in_a),
        .msb_out (msb_a)
    );

    msb_first_shift_reg #(.W(W)) u_sh_b (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (in_shift),
        .din     (in_b),
        .msb_out (msb_b)
    );

    always_comb begin
        in_ready  = 1'b0;
        cmp_clear = 1'b0;
        ser_valid = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        if (!rst) begin
            in_ready  = ready_raw;
            cmp_clear = accept;
            if (in_shift) begin
                ser_valid = 1'b1;
                ser_a     = msb_a;
                ser_b     = msb_b;
                ser_first = (cnt_q == CNT_MAX);
                ser_last  = cnt_zero;
            end
        end
    end

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Bench for serial_pair_serializer_msb_first: cycle-timeline reference model plus an attached MSB-first comparator.
module tb_serial_pair_serializer_msb_first;

    localparam int W  = 8;
    localparam int NC = 3000;
`ifdef SER_PAIR_BACK_TO_BACK_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a     = '0;
    logic [W-1:0] in_b     = '0;
    logic         in_ready, ser_a, ser_b, ser_valid, ser_first, ser_last, cmp_clear;

    serial_pair_serializer_msb_first #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .cmp_clear (cmp_clear)
    );

    always #5 clk = ~clk;

    // Downstream comparator, reset by rst | cmp_clear; outputs from pre-clear state.
    logic gt_q, lt_q, cmp_gt, cmp_lt, cmp_eq;
    always_ff @(posedge clk) begin
        if (rst || cmp_clear) begin
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (ser_valid && !gt_q && !lt_q) begin
            if (ser_a && !ser_b) gt_q <= 1'b1;
            else if (!ser_a && ser_b) lt_q <= 1'b1;
        end
    end
    assign cmp_gt = gt_q || (!lt_q && ser_a && !ser_b);
    assign cmp_lt = lt_q || (!gt_q && !ser_a && ser_b);
    assign cmp_eq = !gt_q && !lt_q && (ser_a == ser_b);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit last_acc;

    // Expected timeline, indexed by cycle number.
    bit exp_v[NC], exp_a[NC], exp_b[NC], exp_f[NC], exp_l[NC], exp_gt[NC], exp_lt[NC], exp_eq[NC];
    // Observed outputs, indexed by cycle number.
    bit act_a[NC], act_b[NC], act_v[NC], act_f[NC], act_l[NC], act_clr[NC], act_rdy[NC];
    bit act_gt[NC], act_lt[NC], act_eq[NC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        bit erdy;
        int c;
        @(negedge clk);
        rst = r; in_valid = v; in_a = a; in_b = b;
        #1;
        c    = cyc;
        erdy = !r && (!exp_v[c] || (BTB && exp_l[c]));
        check("in_ready",  in_ready,  erdy);
        check("cmp_clear", cmp_clear, v && erdy);
        check("ser_valid", ser_valid, !r && exp_v[c]);
        check("ser_a",     ser_a,     !r && exp_v[c] && exp_a[c]);
        check("ser_b",     ser_b,     !r && exp_v[c] && exp_b[c]);
        check("ser_first", ser_first, !r && exp_f[c]);
        check("ser_last",  ser_last,  !r && exp_l[c]);
        if (!r && exp_l[c]) begin
            check("cmp_gt", cmp_gt, exp_gt[c]);
            check("cmp_lt", cmp_lt, exp_lt[c]);
            check("cmp_eq", cmp_eq, exp_eq[c]);
        end
        act_a[c] = ser_a;   act_b[c] = ser_b;     act_v[c] = ser_valid;
        act_f[c] = ser_first; act_l[c] = ser_last; act_clr[c] = cmp_clear;
        act_rdy[c] = in_ready; act_gt[c] = cmp_gt; act_lt[c] = cmp_lt; act_eq[c] = cmp_eq;
        last_acc = v && erdy;
        if (r) begin
            for (int k = 1; k <= W + 1; k++) begin
                exp_v[c+k] = 0; exp_a[c+k] = 0; exp_b[c+k] = 0;
                exp_f[c+k] = 0; exp_l[c+k] = 0;
            end
        end else if (last_acc) begin
            for (int k = 0; k < W; k++) begin
                exp_v[c+1+k]  = 1'b1;
                exp_a[c+1+k]  = a[W-1-k];
                exp_b[c+1+k]  = b[W-1-k];
                exp_f[c+1+k]  = (k == 0);
                exp_l[c+1+k]  = (k == W - 1);
                exp_gt[c+1+k] = (a > b);
                exp_lt[c+1+k] = (a < b);
                exp_eq[c+1+k] = (a == b);
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    // Holds in_valid with a stable word until accepted; t is the accept cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, a, b);
            if (last_acc) begin
                t = cyc - 1;
                break;
            end
        end
        check("accept_timeout", (t >= 0), 1);
        if (t < 0) t = 0;
    endtask

    function automatic logic [W-1:0] gather_a(input int t);
        logic [W-1:0] w = '0;
        for (int k = 0; k < W; k++) w = {w[W-2:0], act_a[t+1+k]};
        return w;
    endfunction

    function automatic logic [W-1:0] gather_b(input int t);
        logic [W-1:0] w = '0;
        for (int k = 0; k < W; k++) w = {w[W-2:0], act_b[t+1+k]};
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, gaps, lasts;
        logic [W-1:0] pa, pb;

        // Reset held three cycles, then ready on the first free cycle.
        repeat (3) step(1'b1, 1'b0, '0, '0);
        check("rst_rdy_low", act_rdy[cyc-1], 0);
        idle(1);
        check("rdy_after_rst", act_rdy[cyc-1], 1);

        // 0xA5 vs 0xA4.
        send(8'hA5, 8'hA4, t);
        idle(10);
        check("a5_clear_at_T", act_clr[t], 1);
        check("a5_bits_a", gather_a(t), 8'hA5);
        check("a5_bits_b", gather_b(t), 8'hA4);
        check("a5_first_T1", act_f[t+1], 1);
        check("a5_last_T8", act_l[t+8], 1);
        check("a5_gt_T8", act_gt[t+8], 1);

        // Two words with in_valid held high.
        send(8'h71, 8'h17, t1);
        send(8'hE2, 8'hE3, t2);
        idle(10);
        check("b2b_spacing", t2 - t1, BTB ? 8 : 9);
        gaps = 0;
        for (int i = t1 + 1; i <= t2 + W; i++) if (!act_v[i]) gaps++;
        check("b2b_gaps", gaps, BTB ? 0 : 1);
        check("b2b_word2_a", gather_a(t2), 8'hE2);
        check("b2b_word2_lt", act_lt[t2+8], 1);

        // Equal words: eq holds through idle.
        send(8'h3C, 8'h3C, t);
        idle(W + 6);
        for (int i = 0; i < 6; i++) check("eq_hold", act_eq[t+8+i], 1);

        // Reset mid-word drops the word, next word clean.
        send(8'h10, 8'h80, t);
        idle(3);
        step(1'b1, 1'b0, '0, '0);
        idle(6);
        check("abort_valid_T5", act_v[t+5], 0);
        lasts = 0;
        for (int i = t + 1; i <= t + 10; i++) if (act_l[i]) lasts++;
        check("abort_no_last", lasts, 0);
        send(8'h01, 8'h02, t);
        idle(10);
        check("after_abort_lt", act_lt[t+8], 1);

        // Word offered mid-shift waits, then goes out unchanged.
        send(8'h5A, 8'hC3, t1);
        idle(2);
        send(8'h96, 8'h69, t2);
        idle(10);
        check("held_accept", t2 - t1, BTB ? 8 : 9);
        check("held_bits_a", gather_a(t2), 8'h96);
        check("held_bits_b", gather_b(t2), 8'h69);

        // Random traffic with occasional resets; word held until accepted.
        pa = W'($urandom);
        pb = W'($urandom);
        for (int i = 0; i < 800 && cyc < NC - 40; i++) begin
            step(($urandom % 50) == 0, ($urandom % 3) != 0, pa, pb);
            if (last_acc) begin
                case ($urandom % 4)
                    0: begin pa = W'($urandom); pb = pa; end
                    1: begin pa = '1; pb = W'($urandom); end
                    default: begin pa = W'($urandom); pb = W'($urandom); end
                endcase
            end
        end
        idle(W + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
